// File: rtl/router_pkg.sv
// router_pkg: shared router widths, header bit positions and VC buffer states.
package router_pkg;
   localparam int DATA_WIDTH = 64;
   localparam int VC_BIT     = 63;
   localparam int DIR_BIT    = 62;
   localparam int HOP_LSB    = 48;
   localparam int HOP_MSB    = 55;
   localparam int VC_EVEN    = 0;
   localparam int VC_ODD     = 1;
   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} buf_state_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: one-hot grant searching upward from pointer; pointer held at 0 gives fixed priority.
module rr_arbiter #(
   parameter int N_REQ = 2,
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic [N_REQ-1:0] req,
   input  logic             enable,
   input  logic [PW-1:0]    pointer,
   output logic [N_REQ-1:0] grant
);
   always_comb begin
      grant = '0;
      for (int k = N_REQ - 1; k >= 0; k--)
         if (enable && req[(int'(pointer) + k) % N_REQ])
            grant = N_REQ'(1) << ((int'(pointer) + k) % N_REQ);
   end
endmodule

// File: rtl/output_vc_arbiter.sv
// output_vc_arbiter: shares an even/odd VC buffer pair between N_REQ inputs and drains the link VC.
// FAIR_RR_EN selects round-robin arbitration; undefined gives fixed lowest-index priority.
module output_vc_arbiter
   import router_pkg::*;
#(
   parameter int DATA_WIDTH = router_pkg::DATA_WIDTH,
   parameter int N_REQ      = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        polarity,
   input  logic [N_REQ-1:0]            req_even,
   input  logic [N_REQ-1:0]            req_odd,
   input  logic [N_REQ*DATA_WIDTH-1:0] data_even,
   input  logic [N_REQ*DATA_WIDTH-1:0] data_odd,
   output logic [N_REQ-1:0]            grant_even,
   output logic [N_REQ-1:0]            grant_odd,
   input  logic                        ri,
   output logic                        so,
   output logic [DATA_WIDTH-1:0]       dout,
   output logic                        full_even,
   output logic                        full_odd
);
   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   buf_state_e st_even, st_odd;
   logic [DATA_WIDTH-1:0] buf_even, buf_odd, win_even, win_odd;
   logic [PW-1:0] ptr_even, ptr_odd;
   assign full_even = (st_even == FULL);
   assign full_odd  = (st_odd == FULL);
   rr_arbiter #(.N_REQ(N_REQ)) u_arb_even (
      .req(req_even), .enable(rst_n && !full_even && !polarity),
      .pointer(ptr_even), .grant(grant_even)
   );
   rr_arbiter #(.N_REQ(N_REQ)) u_arb_odd (
      .req(req_odd), .enable(rst_n && !full_odd && polarity),
      .pointer(ptr_odd), .grant(grant_odd)
   );
   always_comb begin
      win_even = '0;
      win_odd  = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant_even[i]) win_even = data_even[i*DATA_WIDTH +: DATA_WIDTH];
         if (grant_odd[i]) win_odd = data_odd[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end
   // Link VC is always the one opposite to the VC being filled.
   always_comb begin
      so   = rst_n && ri && (polarity ? full_even : full_odd);
      dout = so ? (polarity ? buf_even : buf_odd) : '0;
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_even  <= EMPTY;
         st_odd   <= EMPTY;
         buf_even <= '0;
         buf_odd  <= '0;
      end else begin
         if (|grant_even) begin
            buf_even <= win_even;
            st_even  <= FULL;
         end else if (so && polarity) st_even <= EMPTY;
         if (|grant_odd) begin
            buf_odd <= win_odd;
            st_odd  <= FULL;
         end else if (so && !polarity) st_odd <= EMPTY;
      end
   end
`ifdef FAIR_RR_EN
   function automatic logic [PW-1:0] next_ptr(input logic [N_REQ-1:0] g);
      next_ptr = '0;
      for (int i = 0; i < N_REQ - 1; i++)
         if (g[i]) next_ptr = PW'(i + 1);
   endfunction
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr_even <= '0;
         ptr_odd  <= '0;
      end else begin
         if (|grant_even) ptr_even <= next_ptr(grant_even);
         if (|grant_odd) ptr_odd <= next_ptr(grant_odd);
      end
   end
`else
   assign ptr_even = '0;
   assign ptr_odd  = '0;
`endif
endmodule

// File: tb/tb_output_vc_arbiter.sv
// tb_output_vc_arbiter: directed steps with a scoreboard of flits expected on the link.
module tb_output_vc_arbiter;
   logic         clk = 0;
   logic         rst_n, polarity, ri;
   logic [1:0]   req_even, req_odd, grant_even, grant_odd;
   logic [127:0] data_even, data_odd;
   logic         so, full_even, full_odd;
   logic [63:0]  dout;
   logic [63:0]  sb[$];
   logic [1:0]   exp_g;
   int           n_checks = 0;
   int           n_fail = 0;

   output_vc_arbiter #(.DATA_WIDTH(64), .N_REQ(2)) dut (
      .clk(clk), .rst_n(rst_n), .polarity(polarity),
      .req_even(req_even), .req_odd(req_odd),
      .data_even(data_even), .data_odd(data_odd),
      .grant_even(grant_even), .grant_odd(grant_odd),
      .ri(ri), .so(so), .dout(dout),
      .full_even(full_even), .full_odd(full_odd)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every link strobe must match the oldest flit still owed to the link.
   always @(negedge clk) begin
      if (so === 1'b1) begin
         if (sb.size() == 0) check("unexpected_so", dout, 64'hx);
         else check("link_dout", dout, sb.pop_front());
      end
   end

   initial begin
      rst_n = 0; polarity = 1; ri = 1;
      req_even = 0; req_odd = 2'b11; data_even = '0; data_odd = '0;
      tick(); tick();
      check("rst_grant_odd", 64'(grant_odd), 64'h0);
      check("rst_grant_even", 64'(grant_even), 64'h0);
      check("rst_so", 64'(so), 64'h0);
      check("rst_dout", dout, 64'h0);
      check("rst_full_even", 64'(full_even), 64'h0);
      check("rst_full_odd", 64'(full_odd), 64'h0);

      // single grant on odd, then flip polarity to drain
      rst_n = 1; ri = 0; req_odd = 2'b01; data_odd[63:0] = 64'hA5;
      #1;
      check("single_grant", 64'(grant_odd), 64'h1);
      sb.push_back(64'hA5);
      tick();
      req_odd = 0;
      check("single_full", 64'(full_odd), 64'h1);
      polarity = 0; ri = 1;
      #1;
      check("single_so", 64'(so), 64'h1);
      check("single_dout", dout, 64'hA5);
      tick();
      ri = 0;
      check("single_empty", 64'(full_odd), 64'h0);

      // contention on even VC, draining between grants
      req_even = 2'b11; data_even = {64'hC1, 64'hC0};
      for (int n = 0; n < 3; n++) begin
         polarity = 0; ri = 0;
         #1;
`ifdef FAIR_RR_EN
         exp_g = (n == 1) ? 2'b10 : 2'b01;
`else
         exp_g = 2'b01;
`endif
         check("contend_grant", 64'(grant_even), 64'(exp_g));
         sb.push_back(exp_g[1] ? 64'hC1 : 64'hC0);
         tick();
         polarity = 1; ri = 1;
         tick();
      end
      req_even = 0; ri = 0; polarity = 0;
      tick();
      check("contend_drained", 64'(full_even), 64'h0);

      // full blocking: no grant until the cycle after the drain
      req_even = 2'b01; data_even[63:0] = 64'hD4;
      #1;
      check("block_first", 64'(grant_even), 64'h1);
      sb.push_back(64'hD4);
      tick();
      data_even[63:0] = 64'hD5;
      check("block_held0", 64'(grant_even), 64'h0);
      tick();
      check("block_held1", 64'(grant_even), 64'h0);
      polarity = 1; ri = 1;
      #1;
      check("block_drain_so", 64'(so), 64'h1);
      check("block_drain_grant", 64'(grant_even), 64'h0);
      tick();
      polarity = 0; ri = 0;
      #1;
      check("block_regrant", 64'(grant_even), 64'h1);
      sb.push_back(64'hD5);
      tick();
      req_even = 0;

      // backpressure on the link
      polarity = 1; ri = 0;
      for (int n = 0; n < 5; n++) begin
         tick();
         check("bp_so", 64'(so), 64'h0);
         check("bp_full", 64'(full_even), 64'h1);
      end
      ri = 1;
      #1;
      check("bp_release_dout", dout, 64'hD5);
      tick();
      check("bp_empty", 64'(full_even), 64'h0);
      tick();
      check("bp_no_second", 64'(so), 64'h0);
      ri = 0;

      // reset mid-operation discards the buffered flit
      req_odd = 2'b01; data_odd[63:0] = 64'hFF;
      #1;
      check("mid_grant", 64'(grant_odd), 64'h1);
      tick();
      req_odd = 0;
      check("mid_full", 64'(full_odd), 64'h1);
      rst_n = 0; polarity = 0; ri = 1;
      #1;
      check("mid_rst_so", 64'(so), 64'h0);
      tick();
      rst_n = 1;
      #1;
      check("mid_cleared", 64'(full_odd), 64'h0);
      check("mid_no_so", 64'(so), 64'h0);
      tick(); tick();
      check("sb_empty", 64'(sb.size()), 64'h0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
